// File: rtl/cpu_datapath_if.sv
// Strobe, memory-data and register-observation bundle for the single-bus datapath.
// The control side (master) drives strobes; the datapath (slave) exports register contents.
interface cpu_datapath_if;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        HIin, Loin, PCin, IRin, MARin, Yin;
    logic        MDRin, MDRread;
    logic        Zin, ZHIin, ZLOin;
    logic        HIout, Loout, PCout, MDRout, Yout;
    logic        ZHIout, ZLOout, ZHighSelect, ZLowSelect;
    logic        Cout, InPortout, IncPC;
    logic [4:0]  ALU_opcode;
    logic [31:0] Mdatain;

    logic [31:0] R [16];
    logic [31:0] HI, LO, Y, ZLO, ZHI, IR;
    logic [63:0] Z_register;

    modport master (
        output Rin, Rout, HIin, Loin, PCin, IRin, MARin, Yin, MDRin, MDRread,
               Zin, ZHIin, ZLOin, HIout, Loout, PCout, MDRout, Yout,
               ZHIout, ZLOout, ZHighSelect, ZLowSelect, Cout, InPortout, IncPC,
               ALU_opcode, Mdatain,
        input  R, HI, LO, Y, ZLO, ZHI, IR, Z_register
    );

    modport slave (
        input  Rin, Rout, HIin, Loin, PCin, IRin, MARin, Yin, MDRin, MDRread,
               Zin, ZHIin, ZLOin, HIout, Loout, PCout, MDRout, Yout,
               ZHIout, ZLOout, ZHighSelect, ZLowSelect, Cout, InPortout, IncPC,
               ALU_opcode, Mdatain,
        output R, HI, LO, Y, ZLO, ZHI, IR, Z_register
    );
endinterface

// File: rtl/cpu_datapath.sv
// 32-bit single-bus datapath: 16 GPRs, HI/LO, PC, IR, MAR, MDR, Y, 64-bit Z and a
// combinational ALU computing Y (op) bus into Z.
module cpu_datapath (
    input  logic          clk,
    input  logic          clr,
    cpu_datapath_if.slave dp
);
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    logic [31:0] gpr_q [16];
    logic [31:0] hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, y_q;
    logic [63:0] z_q;
    logic [31:0] pc_d, mdr_d, c_ext, bus_mux;
    logic [63:0] z_d, alu_res;
    logic signed [31:0] a_s, b_s;
    logic [4:0]  shamt;
    logic        unused_mar;

    // MAR is loaded but has no consumer inside this block.
    assign unused_mar = ^mar_q;

    assign c_ext = {{13{ir_q[18]}}, ir_q[18:0]};

    // Lowest-priority sources are applied first so later matches override them.
    always_comb begin
        bus_mux = 32'h0;
        if (dp.Yout)                        bus_mux = y_q;
        if (dp.Cout)                        bus_mux = c_ext;
        if (dp.InPortout)                   bus_mux = 32'h0;
        if (dp.MDRout)                      bus_mux = mdr_q;
        if (dp.PCout)                       bus_mux = pc_q;
        if (dp.ZLOout || dp.ZLowSelect)     bus_mux = z_q[31:0];
        if (dp.ZHIout || dp.ZHighSelect)    bus_mux = z_q[63:32];
        if (dp.Loout)                       bus_mux = lo_q;
        if (dp.HIout)                       bus_mux = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (dp.Rout[i]) bus_mux = gpr_q[i];
        end
    end

    assign a_s   = y_q;
    assign b_s   = bus_mux;
    assign shamt = bus_mux[4:0];

    always_comb begin
        alu_res = 64'h0;
        unique case (dp.ALU_opcode)
            OP_ADD:  alu_res = {32'h0, y_q + bus_mux};
            OP_SUB:  alu_res = {32'h0, y_q - bus_mux};
            OP_AND:  alu_res = {32'h0, y_q & bus_mux};
            OP_OR:   alu_res = {32'h0, y_q | bus_mux};
            OP_SHR:  alu_res = {32'h0, y_q >> shamt};
            OP_SHRA: alu_res = {32'h0, a_s >>> shamt};
            OP_SHL:  alu_res = {32'h0, y_q << shamt};
            OP_ROR:  alu_res = {32'h0, (y_q >> shamt) | (y_q << (6'd32 - {1'b0, shamt}))};
            OP_ROL:  alu_res = {32'h0, (y_q << shamt) | (y_q >> (6'd32 - {1'b0, shamt}))};
            OP_MUL:  alu_res = {{32{y_q[31]}}, y_q} * {{32{bus_mux[31]}}, bus_mux};
            OP_DIV: begin
                // Both corner cases are resolved explicitly rather than left to '/'.
                if (bus_mux == 32'h0)
                    alu_res = {y_q, 32'hFFFF_FFFF};
                else if (y_q == 32'h8000_0000 && bus_mux == 32'hFFFF_FFFF)
                    alu_res = {32'h0, 32'h8000_0000};
                else
                    alu_res = {32'(a_s % b_s), 32'(a_s / b_s)};
            end
            OP_NEG:  alu_res = {32'h0, ~bus_mux + 32'd1};
            OP_NOT:  alu_res = {32'h0, ~bus_mux};
            default: alu_res = 64'h0;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (dp.IncPC)     pc_d = pc_q + 32'd1;
        else if (dp.PCin) pc_d = bus_mux;

        mdr_d = dp.MDRread ? dp.Mdatain : bus_mux;

        z_d = z_q;
        if (dp.Zin) begin
            z_d = alu_res;
        end else begin
            if (dp.ZHIin) z_d[63:32] = alu_res[63:32];
            if (dp.ZLOin) z_d[31:0]  = alu_res[31:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_gpr
            always_ff @(posedge clk or negedge clr) begin
                if (!clr)             gpr_q[gi] <= 32'h0;
                else if (dp.Rin[gi])  gpr_q[gi] <= bus_mux;
            end
            assign dp.R[gi] = gpr_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hi_q  <= 32'h0;
            lo_q  <= 32'h0;
            pc_q  <= 32'h0;
            ir_q  <= 32'h0;
            mar_q <= 32'h0;
            mdr_q <= 32'h0;
            y_q   <= 32'h0;
            z_q   <= 64'h0;
        end else begin
            if (dp.HIin)  hi_q  <= bus_mux;
            if (dp.Loin)  lo_q  <= bus_mux;
            if (dp.IRin)  ir_q  <= bus_mux;
            if (dp.MARin) mar_q <= bus_mux;
            if (dp.MDRin) mdr_q <= mdr_d;
            if (dp.Yin)   y_q   <= bus_mux;
            pc_q <= pc_d;
            z_q  <= z_d;
        end
    end

    assign dp.HI         = hi_q;
    assign dp.LO         = lo_q;
    assign dp.Y          = y_q;
    assign dp.IR         = ir_q;
    assign dp.ZLO        = z_q[31:0];
    assign dp.ZHI        = z_q[63:32];
    assign dp.Z_register = z_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: strobe sequences with hand-computed register results.
module tb_cpu_datapath;
    logic clk;
    logic clr;
    int   n_checks;
    int   n_errors;

    cpu_datapath_if dif ();

    cpu_datapath dut (
        .clk (clk),
        .clr (clr),
        .dp  (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        dif.Rin = '0;  dif.Rout = '0;
        dif.HIin = 0;  dif.Loin = 0;  dif.PCin = 0;  dif.IRin = 0;  dif.MARin = 0;  dif.Yin = 0;
        dif.MDRin = 0; dif.MDRread = 0;
        dif.Zin = 0;   dif.ZHIin = 0; dif.ZLOin = 0;
        dif.HIout = 0; dif.Loout = 0; dif.PCout = 0; dif.MDRout = 0; dif.Yout = 0;
        dif.ZHIout = 0; dif.ZLOout = 0; dif.ZHighSelect = 0; dif.ZLowSelect = 0;
        dif.Cout = 0;  dif.InPortout = 0; dif.IncPC = 0;
        dif.ALU_opcode = 5'b00000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic mem_to_mdr(input logic [31:0] v);
        dif.Mdatain = v; dif.MDRread = 1; dif.MDRin = 1;
        tick();
    endtask

    task automatic load_y(input logic [31:0] v);
        mem_to_mdr(v);
        dif.MDRout = 1; dif.Yin = 1;
        tick();
    endtask

    task automatic load_r(input int idx, input logic [31:0] v);
        mem_to_mdr(v);
        dif.MDRout = 1; dif.Rin[idx] = 1'b1;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 16; i++) check_val($sformatf("%s_R%0d", tag, i), {32'h0, dif.R[i]}, 64'h0);
        check_val({tag, "_HI"}, {32'h0, dif.HI}, 64'h0);
        check_val({tag, "_LO"}, {32'h0, dif.LO}, 64'h0);
        check_val({tag, "_Y"},  {32'h0, dif.Y},  64'h0);
        check_val({tag, "_IR"}, {32'h0, dif.IR}, 64'h0);
        check_val({tag, "_Z"},  dif.Z_register,  64'h0);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] exp;
        string       name;
    } alu_vec_t;

    alu_vec_t vecs [12];

    initial begin
        n_checks = 0;
        n_errors = 0;
        vecs[0]  = '{5'b00011, 32'h8000_00F6, "ADD"};
        vecs[1]  = '{5'b00100, 32'h8000_00EC, "SUB"};
        vecs[2]  = '{5'b00101, 32'h0000_0001, "AND"};
        vecs[3]  = '{5'b00110, 32'h8000_00F5, "OR"};
        vecs[4]  = '{5'b00111, 32'h0400_0007, "SHR"};
        vecs[5]  = '{5'b01000, 32'hFC00_0007, "SHRA"};
        vecs[6]  = '{5'b01001, 32'h0000_1E20, "SHL"};
        vecs[7]  = '{5'b01010, 32'h8C00_0007, "ROR"};
        vecs[8]  = '{5'b01011, 32'h0000_1E30, "ROL"};
        vecs[9]  = '{5'b10001, 32'hFFFF_FFFB, "NEG"};
        vecs[10] = '{5'b10010, 32'hFFFF_FFFA, "NOT"};
        vecs[11] = '{5'b11111, 32'h0000_0000, "UNDEF"};

        // Reset held low with random strobes
        clr = 1'b0;
        idle();
        dif.Mdatain = $urandom;
        dif.Rin = 16'($urandom); dif.Rout = 16'($urandom);
        dif.HIin = 1; dif.Loin = 1; dif.Yin = 1; dif.IRin = 1; dif.Zin = 1;
        dif.MDRin = 1; dif.MDRread = 1; dif.IncPC = 1; dif.ALU_opcode = 5'b10010;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        idle();
        clr = 1'b1;
        tick();
        check_all_zero("rst_hold");

        // Load path through MDR
        load_r(6, 32'h0000_000F);
        check_val("load_R6", {32'h0, dif.R[6]}, 64'h0000_000F);
        load_r(7, 32'h0000_0004);
        check_val("load_R7", {32'h0, dif.R[7]}, 64'h0000_0004);
        dif.MDRout = 1; dif.Rin[1] = 1; tick();
        check_val("load_R1", {32'h0, dif.R[1]}, 64'h0000_0004);
        dif.Rin[1] = 1; tick();
        check_val("empty_bus_R1", {32'h0, dif.R[1]}, 64'h0);

        // DIV 15/4 with split Z load, then Z halves into LO/HI
        dif.Rout[6] = 1; dif.Yin = 1; tick();
        check_val("Y_from_R6", {32'h0, dif.Y}, 64'h0000_000F);
        dif.Rout[7] = 1; dif.ALU_opcode = 5'b10000; dif.ZHIin = 1; dif.ZLOin = 1; tick();
        check_val("div_15_4", dif.Z_register, 64'h0000_0003_0000_0003);
        dif.ZLOout = 1; dif.Loin = 1; tick();
        check_val("LO_from_ZLO", {32'h0, dif.LO}, 64'h3);
        dif.ZHIout = 1; dif.HIin = 1; tick();
        check_val("HI_from_ZHI", {32'h0, dif.HI}, 64'h3);

        // Signed divide -15/4
        load_y(32'hFFFF_FFF1);
        dif.Rout[7] = 1; dif.ALU_opcode = 5'b10000; dif.Zin = 1; tick();
        check_val("div_neg", dif.Z_register, 64'hFFFF_FFFD_FFFF_FFFD);

        // Signed multiply -1*2, then low-half-only load
        load_y(32'hFFFF_FFFF);
        load_r(8, 32'h0000_0002);
        dif.Rout[8] = 1; dif.ALU_opcode = 5'b01111; dif.Zin = 1; tick();
        check_val("mul_neg", dif.Z_register, 64'hFFFF_FFFF_FFFF_FFFE);
        dif.Rout[8] = 1; dif.ALU_opcode = 5'b00011; dif.ZLOin = 1; tick();
        check_val("zlo_only", dif.Z_register, 64'hFFFF_FFFF_0000_0001);

        // Divide by zero and the overflow case
        load_y(32'h0000_0007);
        dif.ALU_opcode = 5'b10000; dif.Zin = 1; tick();
        check_val("div_by_0", dif.Z_register, 64'h0000_0007_FFFF_FFFF);
        load_y(32'h8000_0000);
        load_r(8, 32'hFFFF_FFFF);
        dif.Rout[8] = 1; dif.ALU_opcode = 5'b10000; dif.Zin = 1; dif.ZHIin = 1; tick();
        check_val("div_ovf", dif.Z_register, 64'h0000_0000_8000_0000);

        // Single-word ops: A=800000F1, B=5
        load_y(32'h8000_00F1);
        load_r(8, 32'h0000_0005);
        for (int i = 0; i < 12; i++) begin
            dif.Rout[8] = 1; dif.ALU_opcode = vecs[i].op; dif.Zin = 1; tick();
            check_val(vecs[i].name, dif.Z_register, {32'h0, vecs[i].exp});
        end

        // PC wrap and IncPC priority
        mem_to_mdr(32'hFFFF_FFFF);
        dif.MDRout = 1; dif.PCin = 1; tick();
        dif.PCout = 1; dif.Rin[9] = 1; tick();
        check_val("pc_load", {32'h0, dif.R[9]}, 64'hFFFF_FFFF);
        dif.IncPC = 1; tick();
        dif.PCout = 1; dif.Rin[9] = 1; tick();
        check_val("pc_wrap", {32'h0, dif.R[9]}, 64'h0);
        dif.IncPC = 1; dif.PCin = 1; dif.MDRout = 1; tick();
        dif.PCout = 1; dif.Rin[10] = 1; tick();
        check_val("incpc_prio", {32'h0, dif.R[10]}, 64'h1);

        // C path from IR
        mem_to_mdr(32'h0004_0000);
        dif.MDRout = 1; dif.IRin = 1; tick();
        check_val("IR_load", {32'h0, dif.IR}, 64'h0004_0000);
        dif.Cout = 1; dif.Rin[11] = 1; tick();
        check_val("c_signext", {32'h0, dif.R[11]}, 64'hFFFC_0000);

        // Bus priority
        load_r(2, 32'h2222_2222);
        load_r(5, 32'h5555_5555);
        dif.Rout[2] = 1; dif.Rout[5] = 1; dif.Rin[12] = 1; tick();
        check_val("prio_R2_R5", {32'h0, dif.R[12]}, 64'h2222_2222);
        dif.Rout[5] = 1; dif.Yout = 1; dif.Cout = 1; dif.Rin[12] = 1; tick();
        check_val("prio_R5_Y", {32'h0, dif.R[12]}, 64'h5555_5555);
        dif.Cout = 1; dif.Yout = 1; dif.Rin[12] = 1; tick();
        check_val("prio_C_Y", {32'h0, dif.R[12]}, 64'hFFFC_0000);
        dif.ZHighSelect = 1; dif.Rin[13] = 1; tick();
        check_val("zhi_alias", {32'h0, dif.R[13]}, 64'h0);
        dif.ZLowSelect = 1; dif.Rin[13] = 1; tick();
        check_val("zlo_alias", {32'h0, dif.R[13]}, 64'h0);
        dif.ZLowSelect = 1; dif.Yout = 1; dif.HIin = 1; tick();
        check_val("zlo_over_y", {32'h0, dif.HI}, 64'h0);
        dif.HIout = 1; dif.Yout = 1; dif.Rin[14] = 1; tick();
        check_val("hi_over_y", {32'h0, dif.R[14]}, 64'h0);
        dif.Yout = 1; dif.Rin[14] = 1; tick();
        check_val("y_out", {32'h0, dif.R[14]}, 64'h8000_00F1);
        dif.InPortout = 1; dif.Yout = 1; dif.Rin[14] = 1; tick();
        check_val("inport_zero", {32'h0, dif.R[14]}, 64'h0);

        // Async clear wins over concurrent loads
        dif.Rout[2] = 1; dif.Rin = 16'hFFFB; dif.Yin = 1; dif.HIin = 1; dif.Loin = 1;
        dif.IRin = 1; dif.Zin = 1; dif.ALU_opcode = 5'b00011;
        #2;
        clr = 1'b0;
        #1;
        check_all_zero("async_clr");
        @(posedge clk);
        #1;
        check_all_zero("clr_vs_load");
        idle();
        clr = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
